// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the instruction-fetch slice.
//   XLEN          : datapath / PC width
//   NOP_INSTR     : addi x0,x0,0, shown to IF/ID whenever no instruction is ready
//   fetch_entry_t : {pc, instr} pair held in the fetch buffer and the pc tag queue
//   fetch_state_e : fetch controller states (BOOT, RUN)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small FIFO of fetch_entry_t. Used both as the instruction buffer and as the
// in-order pc tag queue for outstanding memory requests.
// Ports:
//   clk, rst   : clock, async active-high reset
//   flush      : empty the FIFO this cycle (push/pop ignored)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry
//   head       : current head entry (valid when count != 0)
//   count      : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [AW:0]  count
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          empty, full;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // The credit scheme upstream must never overflow or underflow this FIFO.
   assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !pop));
   assert property (@(posedge clk) disable iff (rst) !(pop && !flush && empty));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// IF stage: owns the PC, issues in-order word requests to instruction memory,
// buffers returned words and presents them to the IF/ID register.
// Handshake: a request transfers on a clock edge where imem_req_valid and
// imem_req_ready are both high; valid/addr may change while not accepted.
// Responses carry no handshake: imem_rsp_valid marks one word, returned in
// request order, and is always absorbed (credits bound what can arrive).
// Ports:
//   clk, rst                        : clock, async active-high reset
//   StallF                          : hold the presented instruction
//   PCSrcE, PCTargetE               : redirect from EX (wins over everything)
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_rsp_valid/data             : in-order response channel
//   InstrF, PCF, PCPlus4F           : instruction, its PC and PC+4 for IF/ID
//   FetchValidF                     : InstrF is a real fetched instruction
//   fetch_state_dbg                 : controller state, for observation
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_bubble_cnt                 : saturating count of RUN cycles with no valid output
//   perf_redirect_cnt               : saturating count of PCSrcE cycles
// -----------------------------------------------------------------------------
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            FetchValidF,
   output fetch_state_e    fetch_state_dbg
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_bubble_cnt,
   output logic [31:0]     perf_redirect_cnt
`endif
);

   localparam int AW = $clog2(BUF_DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW:0]     drop_cnt_q, drop_cnt_d;

   fetch_entry_t    buf_head, tag_head, rsp_entry, tag_entry;
   logic [AW:0]     buf_count, tag_count;
   logic            buf_empty;
   logic            req_fire, out_pop, rsp_push;
   logic [AW:0]     credit_used, out_next;

   // Every in-flight request owns one tag entry, so the tag count is the
   // outstanding count.
   assign buf_empty = (buf_count == '0);
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign out_pop   = !buf_empty && !StallF && !PCSrcE;
   // An entry leaving this cycle frees its slot immediately; without this a
   // single-cycle memory could only sustain one instruction every other cycle.
   assign credit_used    = tag_count + buf_count - (AW+1)'(out_pop);
   assign imem_req_valid = (state_q == RUN) && (credit_used < (AW+1)'(BUF_DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign out_next       = tag_count + (AW+1)'(req_fire) - (AW+1)'(imem_rsp_valid);
   // Responses still owed to a pre-redirect PC stream are discarded, as is one
   // arriving in the redirect cycle itself.
   assign rsp_push  = imem_rsp_valid && !PCSrcE && (drop_cnt_q == '0);
   assign tag_entry = '{pc: fetch_pc_q, instr: NOP_INSTR};

   always_comb begin
      rsp_entry       = tag_head;
      rsp_entry.instr = imem_rsp_data;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase
      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - (AW+1)'(1);
      end
      if (PCSrcE) begin
         fetch_pc_d = PCTargetE & ~XLEN'(3);
         drop_cnt_d = out_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_tag_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (tag_entry),
      .pop       (imem_rsp_valid),
      .head      (tag_head),
      .count     (tag_count)
   );

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_ibuf (
      .clk       (clk),
      .rst       (rst),
      .flush     (PCSrcE),
      .push      (rsp_push),
      .push_data (rsp_entry),
      .pop       (out_pop),
      .head      (buf_head),
      .count     (buf_count)
   );

   assign FetchValidF     = !buf_empty;
   assign InstrF          = buf_empty ? NOP_INSTR : buf_head.instr;
   assign PCF             = buf_empty ? '0 : buf_head.pc;
   assign PCPlus4F        = PCF + XLEN'(4);
   assign fetch_state_dbg = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   always_comb begin
      bubble_cnt_d   = bubble_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if ((state_q == RUN) && buf_empty && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
      if (PCSrcE && (redirect_cnt_q != '1)) begin
         redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         bubble_cnt_q   <= bubble_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign perf_bubble_cnt   = bubble_cnt_q;
   assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed vector tables for fetch_unit against a behavioural instruction
// memory that returns the request address as the data word after a fixed
// latency, plus hand sequences for reset and a random-stall scoreboard run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import riscv_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrF, PCF, PCPlus4F;
   logic        FetchValidF;
   fetch_state_e fetch_state_dbg;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt, perf_redirect_cnt;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .StallF          (StallF),
      .PCSrcE          (PCSrcE),
      .PCTargetE       (PCTargetE),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .InstrF          (InstrF),
      .PCF             (PCF),
      .PCPlus4F        (PCPlus4F),
      .FetchValidF     (FetchValidF),
      .fetch_state_dbg (fetch_state_dbg)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubble_cnt   (perf_bubble_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   // ---------------- vector table ----------------
   typedef struct {
      logic        rdy;
      logic        stall;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        ev;
      logic [31:0] epc;
      logic        erv;
      logic        ca;
      logic [31:0] eaddr;
   } vec_t;
   vec_t vq[$];

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic ev, input logic [31:0] epc);
      chk({name, ".valid"}, {31'b0, FetchValidF}, {31'b0, ev});
      chk({name, ".pcf"}, PCF, ev ? epc : 32'h0);
      chk({name, ".instr"}, InstrF, ev ? epc : NOP_INSTR);
      chk({name, ".pcplus4"}, PCPlus4F, ev ? epc + 32'd4 : 32'd4);
   endtask

   // Called at a falling edge with inputs already set: drives the memory
   // response for this cycle, records an accepted request, crosses one rising
   // edge and returns at the next falling edge.
   task automatic step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].addr;
         void'(mq.pop_front());
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      rst            = 1'b1;
      StallF         = 1'b0;
      PCSrcE         = 1'b0;
      PCTargetE      = 32'h0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mq.delete();
      lat = l;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t v(input logic rdy, input logic stall, input logic pcsrc,
                              input logic [31:0] tgt, input logic ev, input logic [31:0] epc,
                              input logic erv, input logic ca, input logic [31:0] eaddr);
      vec_t r;
      r.rdy = rdy; r.stall = stall; r.pcsrc = pcsrc; r.tgt = tgt;
      r.ev = ev; r.epc = epc; r.erv = erv; r.ca = ca; r.eaddr = eaddr;
      return r;
   endfunction

   task automatic run_vecs(input string name);
      for (int i = 0; i < vq.size(); i++) begin
         imem_req_ready = vq[i].rdy;
         StallF         = vq[i].stall;
         PCSrcE         = vq[i].pcsrc;
         PCTargetE      = vq[i].tgt;
         step();
         check_out($sformatf("%s[%0d]", name, i), vq[i].ev, vq[i].epc);
         chk($sformatf("%s[%0d].req_valid", name, i), {31'b0, imem_req_valid}, {31'b0, vq[i].erv});
         if (vq[i].ca) begin
            chk($sformatf("%s[%0d].req_addr", name, i), imem_req_addr, vq[i].eaddr);
         end
      end
      vq.delete();
      StallF = 1'b0;
      PCSrcE = 1'b0;
      imem_req_ready = 1'b1;
   endtask

   task automatic check_reset_outputs(input string name);
      check_out(name, 1'b0, 32'h0);
      chk({name, ".req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      chk({name, ".state"}, 32'(fetch_state_dbg), 32'(BOOT));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main ----------------
   initial begin
      int consumed;
      rst = 1'b1;
      StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      @(negedge clk);
      #1;
      check_reset_outputs("reset");

      // Streaming, ready-low hold at 0x10, then a 5-cycle stall (1-cycle memory).
      do_reset(1);
      vq.push_back(v(1, 0, 0, 0, 0, 32'h00, 1, 1, 32'h00));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h00, 1, 1, 32'h04));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h08));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h04, 1, 1, 32'h0c));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h08, 1, 1, 32'h10));
      vq.push_back(v(0, 0, 0, 0, 1, 32'h0c, 1, 1, 32'h10));
      vq.push_back(v(0, 0, 0, 0, 0, 32'h00, 1, 1, 32'h10));
      vq.push_back(v(0, 0, 0, 0, 0, 32'h00, 1, 1, 32'h10));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h00, 1, 1, 32'h14));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h10, 1, 1, 32'h18));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h14, 1, 1, 32'h1c));
      for (int i = 0; i < 5; i++) begin
         vq.push_back(v(1, 1, 0, 0, 1, 32'h14, 0, 0, 32'h00));
      end
      vq.push_back(v(1, 0, 0, 0, 1, 32'h18, 1, 1, 32'h20));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h1c, 1, 1, 32'h24));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h20, 1, 1, 32'h28));
      run_vecs("stream");
      chk("state_run", 32'(fetch_state_dbg), 32'(RUN));

      // Redirect to 0x100 with two requests in flight (3-cycle memory).
      do_reset(3);
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h000));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h004));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 0, 0, 32'h000));
      vq.push_back(v(1, 0, 1, 32'h100, 0, 32'h000, 0, 1, 32'h100));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h100));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h104));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 0, 0, 32'h000));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 0, 0, 32'h000));
      vq.push_back(v(1, 0, 0, 0,       1, 32'h100, 1, 1, 32'h108));
      vq.push_back(v(1, 0, 0, 0,       1, 32'h104, 1, 1, 32'h10c));
      run_vecs("redir");

      // Redirect coincident with a response and an accepted request; the
      // misaligned target is forced down to 0x200.
      do_reset(1);
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h000));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h004));
      vq.push_back(v(1, 0, 1, 32'h202, 0, 32'h000, 1, 1, 32'h200));
      vq.push_back(v(1, 0, 0, 0,       0, 32'h000, 1, 1, 32'h204));
      vq.push_back(v(1, 0, 0, 0,       1, 32'h200, 1, 1, 32'h208));
      vq.push_back(v(1, 0, 0, 0,       1, 32'h204, 1, 1, 32'h20c));
      run_vecs("coinc");

      // Reset asserted with two requests outstanding.
      do_reset(3);
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h0));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h4));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
      run_vecs("pre_rst");
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      do_reset(3);
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h0));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h4));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
      vq.push_back(v(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h0, 1, 1, 32'h8));
      vq.push_back(v(1, 0, 0, 0, 1, 32'h4, 1, 1, 32'hc));
      run_vecs("post_rst");

      // Random stall / ready: every consumed instruction must be the next PC
      // in sequence, and in-flight requests never exceed the buffer depth.
      do_reset(2);
      for (int i = 0; i < 400; i++) begin
         exp_q.push_back(32'(i * 4));
      end
      consumed = 0;
      for (int c = 0; c < 300; c++) begin
         StallF         = ($urandom_range(0, 3) == 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         if (FetchValidF && !StallF) begin
            if (exp_q.size() == 0) begin
               chk("sb_queue_empty", PCF, 32'hffff_ffff);
            end else begin
               chk($sformatf("sb_pc[%0d]", consumed), PCF, exp_q.pop_front());
               chk($sformatf("sb_instr[%0d]", consumed), InstrF, PCF);
            end
            consumed++;
         end
         step();
         chk($sformatf("sb_inflight[%0d]", c), {31'b0, (mq.size() <= 2)}, 32'd1);
      end
      chk("sb_progress", {31'b0, (consumed >= 50)}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
